// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one combinational-read memory between two requesters.
// Port 0 is the processor bus, port 1 the loader/DMA. Each transaction takes three
// cycles: grant and latch in IDLE, drive the memory in ACCESS, pulse ack in RESP.
// Build option MEM_ARB_ROUND_ROBIN_EN: when defined, ties go to the port that did
// not win last time; when undefined, port 0 wins every tie.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;   // port holding the current transaction
  logic              last_q, last_d;     // port of the most recent grant
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic              p0_ack_q, p0_ack_d;
  logic              p1_ack_q, p1_ack_d;

  logic              grant;              // winning port if a grant happens this cycle

  // Arbitration: a lone request always wins; ties resolved by the build option
  always_comb begin
    grant = 1'b0;
    if (p0_req && p1_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grant = ~last_q;
`else
      grant = 1'b0;
`endif
    end else if (p1_req) begin
      grant = 1'b1;
    end
  end

  // Next-state logic: grant/latch in IDLE, capture read data in ACCESS, ack in RESP
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    p0_ack_d   = 1'b0;
    p1_ack_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (p0_req || p1_req) begin
          owner_d = grant;
          last_d  = grant;
          if (grant) begin
            we_d    = p1_we;
            addr_d  = p1_addr;
            wdata_d = p1_wdata;
          end else begin
            we_d    = p0_we;
            addr_d  = p0_addr;
            wdata_d = p0_wdata;
          end
          state_d = StAccess;
        end
      end

      StAccess: begin
        // Memory read is combinational from mem_addr, so sample it at the end of ACCESS
        if (!we_q) begin
          if (owner_q) begin
            p1_rdata_d = mem_rdata;
          end else begin
            p0_rdata_d = mem_rdata;
          end
        end
        // Ack is registered so it appears exactly during RESP
        p0_ack_d = ~owner_q;
        p1_ack_d = owner_q;
        state_d  = StResp;
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
      p0_ack_q   <= 1'b0;
      p1_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
      p0_ack_q   <= p0_ack_d;
      p1_ack_q   <= p1_ack_d;
    end
  end

  // Memory bus follows the latched operands; the strobe is gated by rst so a write
  // caught mid-ACCESS by reset never reaches the array.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = (state_q == StAccess) & we_q & ~rst;

  assign busy      = (state_q != StIdle);
  assign p0_ack    = p0_ack_q;
  assign p1_ack    = p1_ack_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

endmodule
